// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

    // Number of skewed slices needed to push an N x N operand through the array.
    function automatic int steps_for(input int size);
        return 2 * size - 1;
    endfunction

    // Bit offset of a lane inside a packed stream word.
    function automatic int lane_pack(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_matrix_feeder_skew_lane_mux.sv
// Picks element (t - LANE) of a stored row/column for one skewed lane, zero outside the matrix.
// Purely combinational.
module skew_lane_mux
    import systolic_pkg::*;
#(
    parameter int SIZE   = 2,
    parameter int WIDTHx = 8,
    parameter int LANE   = 0,
    parameter int TW     = 2
) (
    input  logic [TW-1:0]          t_i,
    input  logic [SIZE*WIDTHx-1:0] vec_i,
    output logic [WIDTHx-1:0]      elem_o
);

    always_comb begin
        elem_o = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (int'(t_i) == LANE + k) begin
                elem_o = vec_i[lane_pack(k, WIDTHx) +: WIDTHx];
            end
        end
    end

endmodule

// File: rtl/systolic_matrix_feeder.sv
// Captures an A/B matrix pair, replays it as diagonally skewed zero-padded slices, then waits for done_i.
// Optional WAIT_DONE watchdog with sticky timeout_o under SYSTOLIC_FEEDER_TIMEOUT_EN.
module systolic_matrix_feeder
    import systolic_pkg::*;
#(
    parameter int SIZE    = 2,
    parameter int WIDTHx  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     mat_valid_i,
    output logic                     mat_ready_o,
    input  logic [WIDTHx-1:0]        a_matrix_i [SIZE][SIZE],
    input  logic [WIDTHx-1:0]        b_matrix_i [SIZE][SIZE],
    output logic                     valid_o,
    output logic [WIDTHx*SIZE-1:0]   a_stream_o,
    output logic [WIDTHx*SIZE-1:0]   b_stream_o,
    input  logic                     done_i,
    output logic                     busy_o
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    ,
    output logic                     timeout_o
`endif
);

    localparam int STEPS = steps_for(SIZE);
    localparam int TW    = $clog2(2 * SIZE);

    feeder_state_t             state_q, state_d;
    logic [TW-1:0]             t_q, t_d;
    logic [WIDTHx-1:0]         a_mat_q [SIZE][SIZE];
    logic [WIDTHx-1:0]         a_mat_d [SIZE][SIZE];
    logic [WIDTHx-1:0]         b_mat_q [SIZE][SIZE];
    logic [WIDTHx-1:0]         b_mat_d [SIZE][SIZE];
    logic                      mat_ready_q, valid_q, busy_q;
    logic [WIDTHx*SIZE-1:0]    a_stream_q, b_stream_q;
    logic [WIDTHx*SIZE-1:0]    a_lane_d, b_lane_d;
    logic                      capture;
    logic                      wd_expired;

    assign capture = (state_q == IDLE) && mat_valid_i && mat_ready_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_mat_d = a_mat_q;
        b_mat_d = b_mat_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    a_mat_d = a_matrix_i;
                    b_mat_d = b_matrix_i;
                    t_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (t_q == TW'(STEPS - 1)) begin
                    state_d = WAIT_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (done_i || wd_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lanes are evaluated on next-state values so the registered streams line up with t.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [SIZE*WIDTHx-1:0] a_row;
        logic [SIZE*WIDTHx-1:0] b_col;
        logic [WIDTHx-1:0]      a_elem;
        logic [WIDTHx-1:0]      b_elem;

        for (genvar k = 0; k < SIZE; k++) begin : g_pack
            assign a_row[lane_pack(k, WIDTHx) +: WIDTHx] = a_mat_d[i][k];
            assign b_col[lane_pack(k, WIDTHx) +: WIDTHx] = b_mat_d[k][i];
        end

        skew_lane_mux #(.SIZE(SIZE), .WIDTHx(WIDTHx), .LANE(i), .TW(TW)) u_a_mux (
            .t_i    (t_d),
            .vec_i  (a_row),
            .elem_o (a_elem)
        );

        skew_lane_mux #(.SIZE(SIZE), .WIDTHx(WIDTHx), .LANE(i), .TW(TW)) u_b_mux (
            .t_i    (t_d),
            .vec_i  (b_col),
            .elem_o (b_elem)
        );

        assign a_lane_d[lane_pack(i, WIDTHx) +: WIDTHx] = a_elem;
        assign b_lane_d[lane_pack(i, WIDTHx) +: WIDTHx] = b_elem;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            a_mat_q     <= '{default: '0};
            b_mat_q     <= '{default: '0};
            mat_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            a_stream_q  <= '0;
            b_stream_q  <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            a_mat_q     <= a_mat_d;
            b_mat_q     <= b_mat_d;
            mat_ready_q <= (state_d == IDLE);
            valid_q     <= (state_d == STREAM) && (t_d == '0) && (state_q == IDLE);
            busy_q      <= (state_d != IDLE);
            a_stream_q  <= (state_d == STREAM) ? a_lane_d : '0;
            b_stream_q  <= (state_d == STREAM) ? b_lane_d : '0;
        end
    end

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;

    assign wd_expired = (state_q == WAIT_DONE) && !done_i && (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        timeout_d = timeout_q;
        wd_d      = '0;
        if (capture) begin
            timeout_d = 1'b0;
        end
        if (wd_expired) begin
            timeout_d = 1'b1;
        end else if ((state_q == WAIT_DONE) && !done_i) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expired = 1'b0;
`endif

    assign mat_ready_o = mat_ready_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign a_stream_o  = a_stream_q;
    assign b_stream_o  = b_stream_q;

endmodule

// File: tb/tb_systolic_matrix_feeder.sv
// Randomized bench for systolic_matrix_feeder against a skew-formula reference model.
module tb_systolic_matrix_feeder;

    localparam int SIZE    = 2;
    localparam int W       = 8;
    localparam int TIMEOUT = 8;
    localparam int STEPS   = 2 * SIZE - 1;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    logic                mat_valid_i = 1'b0;
    logic                done_i      = 1'b0;
    logic [W-1:0]        a_mat [SIZE][SIZE];
    logic [W-1:0]        b_mat [SIZE][SIZE];
    logic                mat_ready_o, valid_o, busy_o;
    logic [SIZE*W-1:0]   a_stream_o, b_stream_o;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    logic                timeout_o;
`endif

    systolic_matrix_feeder #(.SIZE(SIZE), .WIDTHx(W), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .mat_valid_i (mat_valid_i),
        .mat_ready_o (mat_ready_o),
        .a_matrix_i  (a_mat),
        .b_matrix_i  (b_mat),
        .valid_o     (valid_o),
        .a_stream_o  (a_stream_o),
        .b_stream_o  (b_stream_o),
        .done_i      (done_i),
        .busy_o      (busy_o)
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
        ,
        .timeout_o   (timeout_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]      ma [SIZE][SIZE];
    logic [W-1:0]      mb [SIZE][SIZE];
    logic [SIZE*W-1:0] tab_a [STEPS];
    logic [SIZE*W-1:0] tab_b [STEPS];
    bit                use_tab = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Slice t of the skewed A stream: lane i carries A[i][t-i] when that column exists.
    function automatic logic [SIZE*W-1:0] model_a(input int t);
        logic [SIZE*W-1:0] v = '0;
        for (int i = 0; i < SIZE; i++)
            if (t - i >= 0 && t - i < SIZE) v[i*W +: W] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [SIZE*W-1:0] model_b(input int t);
        logic [SIZE*W-1:0] v = '0;
        for (int j = 0; j < SIZE; j++)
            if (t - j >= 0 && t - j < SIZE) v[j*W +: W] = mb[t-j][j];
        return v;
    endfunction

    task automatic load_random();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ma[i][j] = W'($urandom());
                mb[i][j] = W'($urandom());
            end
    endtask

    task automatic drive_matrices();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                a_mat[i][j] = ma[i][j];
                b_mat[i][j] = mb[i][j];
            end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},   mat_ready_o, 1);
        check({tag, "_busy"},  busy_o,      0);
        check({tag, "_valid"}, valid_o,     0);
        check({tag, "_a"},     a_stream_o,  0);
        check({tag, "_b"},     b_stream_o,  0);
    endtask

    // One full transaction from IDLE; keep_valid leaves mat_valid_i high for back-to-back capture.
    task automatic send(input bit early_done, input int wait_cycles, input bit keep_valid);
        drive_matrices();
        mat_valid_i = 1'b1;
        check("cap_rdy", mat_ready_o, 1);
        step();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                a_mat[i][j] = W'($urandom());
                b_mat[i][j] = W'($urandom());
            end
        mat_valid_i = keep_valid;
        for (int t = 0; t < STEPS; t++) begin
            check("st_valid", valid_o, (t == 0));
            check("st_a", a_stream_o, use_tab ? tab_a[t] : model_a(t));
            check("st_b", b_stream_o, use_tab ? tab_b[t] : model_b(t));
            check("st_busy", busy_o, 1);
            check("st_rdy", mat_ready_o, 0);
            done_i = early_done && (t == 1);
            step();
        end
        done_i = 1'b0;
        for (int c = 0; c < wait_cycles; c++) begin
            check("wd_a", a_stream_o, 0);
            check("wd_b", b_stream_o, 0);
            check("wd_valid", valid_o, 0);
            check("wd_busy", busy_o, 1);
            check("wd_rdy", mat_ready_o, 0);
            step();
        end
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("rel_rdy", mat_ready_o, 1);
        check("rel_busy", busy_o, 0);
    endtask

    initial begin
        bit prev_kv;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                a_mat[i][j] = '0;
                b_mat[i][j] = '0;
            end

        repeat (2) @(negedge clock);
        check_idle("rst");
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
        check("rst_timeout", timeout_o, 0);
`endif
        nreset = 1'b1;
        step();
        check_idle("post_rst");

        ma = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
        mb = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
        tab_a = '{16'h0001, 16'h0302, 16'h0400};
        tab_b = '{16'h0005, 16'h0607, 16'h0800};
        use_tab = 1'b1;
        send(1'b0, 2, 1'b0);
        use_tab = 1'b0;

        // Back-pressure: source holds valid through WAIT_DONE, next pair must land right after ready rises.
        load_random();
        send(1'b0, 4, 1'b1);
        load_random();
        send(1'b0, 1, 1'b0);

        load_random();
        send(1'b1, 3, 1'b0);

        // Reset in the middle of a stream.
        load_random();
        drive_matrices();
        mat_valid_i = 1'b1;
        step();
        mat_valid_i = 1'b0;
        check("mid_valid0", valid_o, 1);
        step();
        check("mid_a1", a_stream_o, model_a(1));
        check("mid_b1", b_stream_o, model_b(1));
        nreset = 1'b0;
        #1;
        check_idle("mid_rst");
        @(negedge clock);
        nreset = 1'b1;
        step();
        check_idle("after_rst");
        load_random();
        send(1'b0, 0, 1'b0);

        prev_kv = 1'b0;
        for (int n = 0; n < 12; n++) begin
            bit ed, kv;
            int wc;
            load_random();
            ed = 1'($urandom_range(0, 1));
            wc = ed ? $urandom_range(2, 6) : $urandom_range(0, 6);
            kv = (n < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!prev_kv) begin
                repeat ($urandom_range(0, 2)) begin
                    check_idle("gap");
                    step();
                end
            end
            send(ed, wc, kv);
            prev_kv = kv;
        end

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
        load_random();
        drive_matrices();
        mat_valid_i = 1'b1;
        step();
        mat_valid_i = 1'b0;
        for (int t = 1; t < STEPS; t++) step();
        step();
        for (int c = 0; c < TIMEOUT; c++) begin
            check("to_busy", busy_o, 1);
            check("to_flag_low", timeout_o, 0);
            step();
        end
        check("to_idle_busy", busy_o, 0);
        check("to_idle_rdy", mat_ready_o, 1);
        check("to_flag", timeout_o, 1);
        step();
        check("to_sticky", timeout_o, 1);
        load_random();
        send(1'b0, 1, 1'b0);
        check("to_cleared", timeout_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
